// File: rtl/dmem_bus_master.sv
// Data-memory bus initiator: turns one core load/store into a single DAD/DDT/MREQ
// bus transaction, stalls the core meanwhile, and returns extended load data.
module dmem_bus_master #(
    parameter int                   BIT_WIDTH      = 32,
    parameter int                   TIMEOUT_CYCLES = 64,
    parameter logic [BIT_WIDTH-1:0] STDOUT_ADDR    = 32'hf000_0000
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 req_valid,
    input  logic                 req_write,
    input  logic [1:0]           req_size,
    input  logic                 req_unsigned,
    input  logic [BIT_WIDTH-1:0] req_addr,
    input  logic [BIT_WIDTH-1:0] req_wdata,
    output logic                 busy,
    output logic                 rsp_valid,
    output logic [BIT_WIDTH-1:0] rsp_rdata,
    output logic                 rsp_err,
    output logic [BIT_WIDTH-1:0] DAD,
    output logic                 MREQ,
    output logic                 WRITE,
    output logic [1:0]           SIZE,
    input  logic                 ACKD_n,
    inout  wire  [BIT_WIDTH-1:0] DDT
);

    localparam int                 CNT_W    = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_REQ  = 2'b01,
        ST_RESP = 2'b10
    } state_t;

    state_t               state_r;
    logic [CNT_W-1:0]     cnt_r;
    logic [BIT_WIDTH-1:0] wdata_r;
    logic                 unsigned_r;
    logic                 misaligned_s;

    function automatic logic [BIT_WIDTH-1:0] store_format(input logic [1:0] size,
                                                           input logic [BIT_WIDTH-1:0] d);
        case (size)
            2'b00:   return d;
            2'b01:   return {{(BIT_WIDTH-16){1'b0}}, d[15:0]};
            default: return {{(BIT_WIDTH-8){1'b0}}, d[7:0]};
        endcase
    endfunction

    // Sub-word loads only look at the low lane; upper DDT bits are discarded.
    function automatic logic [BIT_WIDTH-1:0] load_extend(input logic [1:0] size,
                                                          input logic uns,
                                                          input logic [BIT_WIDTH-1:0] d);
        case (size)
            2'b00:   return d;
            2'b01:   return {{(BIT_WIDTH-16){d[15] & ~uns}}, d[15:0]};
            default: return {{(BIT_WIDTH-8){d[7] & ~uns}}, d[7:0]};
        endcase
    endfunction

    // Alignment check; the stdout byte port is always accepted.
    always_comb begin
        misaligned_s = 1'b0;
        if (req_addr == STDOUT_ADDR) begin
            misaligned_s = 1'b0;
        end else begin
            case (req_size)
                2'b00:   misaligned_s = (req_addr[1:0] != 2'b00);
                2'b01:   misaligned_s = req_addr[0];
                default: misaligned_s = 1'b0;
            endcase
        end
    end

    assign busy = (state_r != ST_IDLE);
    assign DDT  = (MREQ && WRITE) ? wdata_r : {BIT_WIDTH{1'bz}};

    // Transaction FSM with registered bus and response outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r    <= ST_IDLE;
            cnt_r      <= {CNT_W{1'b0}};
            wdata_r    <= {BIT_WIDTH{1'b0}};
            unsigned_r <= 1'b0;
            DAD        <= {BIT_WIDTH{1'b0}};
            MREQ       <= 1'b0;
            WRITE      <= 1'b0;
            SIZE       <= 2'b00;
            rsp_valid  <= 1'b0;
            rsp_rdata  <= {BIT_WIDTH{1'b0}};
            rsp_err    <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    rsp_valid <= 1'b0;
                    rsp_err   <= 1'b0;
                    if (req_valid) begin
                        if (misaligned_s) begin
                            rsp_valid <= 1'b1;
                            rsp_err   <= 1'b1;
                            rsp_rdata <= {BIT_WIDTH{1'b0}};
                            state_r   <= ST_RESP;
                        end else begin
                            DAD        <= req_addr;
                            WRITE      <= req_write;
                            SIZE       <= req_size;
                            unsigned_r <= req_unsigned;
                            wdata_r    <= store_format(req_size, req_wdata);
                            MREQ       <= 1'b1;
                            cnt_r      <= {CNT_W{1'b0}};
                            state_r    <= ST_REQ;
                        end
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_REQ: begin
                    // ACK is checked first so it wins over a same-edge timeout.
                    if (MREQ && !ACKD_n) begin
                        MREQ      <= 1'b0;
                        WRITE     <= 1'b0;
                        rsp_valid <= 1'b1;
                        rsp_err   <= 1'b0;
                        rsp_rdata <= WRITE ? {BIT_WIDTH{1'b0}} : load_extend(SIZE, unsigned_r, DDT);
                        state_r   <= ST_RESP;
                    end else if (cnt_r == CNT_LAST) begin
                        MREQ      <= 1'b0;
                        WRITE     <= 1'b0;
                        rsp_valid <= 1'b1;
                        rsp_err   <= 1'b1;
                        rsp_rdata <= {BIT_WIDTH{1'b0}};
                        state_r   <= ST_RESP;
                    end else begin
                        cnt_r <= cnt_r + CNT_W'(1);
                    end
                end
                ST_RESP: begin
                    rsp_valid <= 1'b0;
                    rsp_err   <= 1'b0;
                    state_r   <= ST_IDLE;
                end
                default: begin
                    MREQ      <= 1'b0;
                    WRITE     <= 1'b0;
                    rsp_valid <= 1'b0;
                    rsp_err   <= 1'b0;
                    state_r   <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_bus_master.sv
// Directed bench for dmem_bus_master: vector table of single transactions plus
// hand sequences for reset, timeout, late ACK and reset during a bus cycle.
module tb_dmem_bus_master;

    localparam int          W      = 32;
    localparam logic [31:0] STDOUT = 32'hf000_0000;
    localparam logic [31:0] PAT    = 32'h5a5a_a5a5;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          req_valid = 1'b0;
    logic          req_write = 1'b0;
    logic [1:0]    req_size = 2'b00;
    logic          req_unsigned = 1'b0;
    logic [W-1:0]  req_addr = 32'h0;
    logic [W-1:0]  req_wdata = 32'h0;
    logic          busy, rsp_valid, rsp_err, MREQ, WRITE;
    logic [W-1:0]  rsp_rdata, DAD;
    logic [1:0]    SIZE;
    logic          ACKD_n = 1'b1;
    logic          mem_oe = 1'b0;
    logic [W-1:0]  mem_drive = 32'h0;
    wire  [W-1:0]  DDT;

    assign DDT = mem_oe ? mem_drive : {W{1'bz}};

    dmem_bus_master #(.BIT_WIDTH(W), .TIMEOUT_CYCLES(4), .STDOUT_ADDR(STDOUT)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_write(req_write),
        .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
        .req_wdata(req_wdata), .busy(busy), .rsp_valid(rsp_valid),
        .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .DAD(DAD), .MREQ(MREQ),
        .WRITE(WRITE), .SIZE(SIZE), .ACKD_n(ACKD_n), .DDT(DDT)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        string       name;
        logic        wr;
        logic [1:0]  size;
        logic        uns;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] mem;
        logic [31:0] exp_rdata;
        logic [31:0] exp_ddt;
        logic        exp_err;
    } vec_t;

    vec_t vecs[12];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // With the DUT released, a value the bench puts on DDT must read back unchanged.
    task automatic check_released(input string name);
        mem_drive = PAT;
        mem_oe    = 1'b1;
        #1;
        check({name, " ddt_released"}, DDT, PAT);
        mem_oe = 1'b0;
    endtask

    task automatic issue(input logic wr, input logic [1:0] size, input logic uns,
                         input logic [31:0] addr, input logic [31:0] wdata);
        req_valid    = 1'b1;
        req_write    = wr;
        req_size     = size;
        req_unsigned = uns;
        req_addr     = addr;
        req_wdata    = wdata;
        @(posedge clk); #1;
        req_valid = 1'b0;
    endtask

    task automatic run_vec(input vec_t v);
        issue(v.wr, v.size, v.uns, v.addr, v.wdata);
        check({v.name, " busy_accept"}, busy, 1'b1);
        if (v.exp_err) begin
            check({v.name, " err_valid"}, rsp_valid, 1'b1);
            check({v.name, " err_flag"}, rsp_err, 1'b1);
            check({v.name, " err_no_mreq"}, MREQ, 1'b0);
            @(posedge clk); #1;
            check({v.name, " err_mreq_after"}, MREQ, 1'b0);
        end else begin
            check({v.name, " mreq"}, MREQ, 1'b1);
            check({v.name, " early_valid"}, rsp_valid, 1'b0);
            check({v.name, " size"}, SIZE, v.size);
            check({v.name, " dad"}, DAD, v.addr);
            check({v.name, " write"}, WRITE, v.wr);
            if (v.wr) begin
                check({v.name, " ddt_store"}, DDT, v.exp_ddt);
            end else begin
                mem_drive = v.mem;
                mem_oe    = 1'b1;
            end
            ACKD_n = 1'b0;
            @(posedge clk); #1;
            ACKD_n = 1'b1;
            mem_oe = 1'b0;
            check({v.name, " rsp_valid"}, rsp_valid, 1'b1);
            check({v.name, " rsp_err"}, rsp_err, 1'b0);
            check({v.name, " rsp_rdata"}, rsp_rdata, v.exp_rdata);
            check({v.name, " mreq_drop"}, MREQ, 1'b0);
            check_released(v.name);
            @(posedge clk); #1;
        end
        check({v.name, " valid_pulse_end"}, rsp_valid, 1'b0);
        check({v.name, " busy_end"}, busy, 1'b0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int idle_bad;
        int mreq_cycles;
        int got_rsp;
        int stray;

        vecs[0]  = '{"LW",      1'b0, 2'b00, 1'b0, 32'h0800_0010, 32'h0,          32'h8000_0001, 32'h8000_0001, 32'h0,          1'b0};
        vecs[1]  = '{"LB",      1'b0, 2'b10, 1'b0, 32'h0800_0003, 32'h0,          32'h0000_0080, 32'hffff_ff80, 32'h0,          1'b0};
        vecs[2]  = '{"LBU",     1'b0, 2'b10, 1'b1, 32'h0800_0003, 32'h0,          32'h0000_0080, 32'h0000_0080, 32'h0,          1'b0};
        vecs[3]  = '{"LH",      1'b0, 2'b01, 1'b0, 32'h0800_0002, 32'h0,          32'h0000_8001, 32'hffff_8001, 32'h0,          1'b0};
        vecs[4]  = '{"LHU",     1'b0, 2'b01, 1'b1, 32'h0800_0002, 32'h0,          32'habcd_8001, 32'h0000_8001, 32'h0,          1'b0};
        vecs[5]  = '{"LB11",    1'b0, 2'b11, 1'b0, 32'h0800_0005, 32'h0,          32'h1234_567f, 32'h0000_007f, 32'h0,          1'b0};
        vecs[6]  = '{"SH",      1'b1, 2'b01, 1'b0, 32'h0800_0002, 32'hdead_beef,  32'h0,         32'h0,         32'h0000_beef, 1'b0};
        vecs[7]  = '{"SW_mis",  1'b1, 2'b00, 1'b0, 32'h0800_0006, 32'h1111_2222,  32'h0,         32'h0,         32'h0,          1'b1};
        vecs[8]  = '{"SB_out",  1'b1, 2'b10, 1'b0, STDOUT,        32'h0000_0041,  32'h0,         32'h0,         32'h0000_0041, 1'b0};
        vecs[9]  = '{"SW",      1'b1, 2'b00, 1'b0, 32'h0800_0020, 32'h1234_5678,  32'h0,         32'h0,         32'h1234_5678, 1'b0};
        vecs[10] = '{"LH_mis",  1'b0, 2'b01, 1'b0, 32'h0800_0001, 32'h0,          32'h0,         32'h0,         32'h0,          1'b1};
        vecs[11] = '{"SB",      1'b1, 2'b10, 1'b0, 32'h0800_0007, 32'hffff_ffaa,  32'h0,         32'h0,         32'h0000_00aa, 1'b0};

        // Reset state.
        #2;
        check("rst mreq", MREQ, 1'b0);
        check("rst busy", busy, 1'b0);
        check("rst rsp_valid", rsp_valid, 1'b0);
        check("rst dad", DAD, 32'h0);
        check("rst size", SIZE, 2'b00);
        check_released("rst");
        @(posedge clk); #1;
        rst = 1'b0;

        // Idle bus with no requests for ten cycles.
        idle_bad = 0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            if (MREQ || busy || rsp_valid) idle_bad++;
        end
        check("idle_10_cycles", idle_bad, 0);

        for (int i = 0; i < 12; i++) run_vec(vecs[i]);

        // ACKD_n never asserted: MREQ held for four cycles, then error.
        issue(1'b0, 2'b00, 1'b0, 32'h0800_0040, 32'h0);
        mreq_cycles = 0;
        got_rsp     = 0;
        for (int i = 0; i < 20; i++) begin
            if (MREQ) mreq_cycles++;
            if (rsp_valid) begin
                got_rsp = 1;
                break;
            end
            @(posedge clk); #1;
        end
        check("timeout got_rsp", got_rsp, 1);
        check("timeout mreq_cycles", mreq_cycles, 4);
        check("timeout rsp_err", rsp_err, 1'b1);
        check("timeout rsp_rdata", rsp_rdata, 32'h0);
        @(posedge clk); #1;
        check("timeout busy_end", busy, 1'b0);

        // ACK arriving on the same edge the timeout would fire: normal completion.
        issue(1'b0, 2'b00, 1'b0, 32'h0800_0044, 32'h0);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
        end
        check("late_ack mreq_held", MREQ, 1'b1);
        check("late_ack no_early_rsp", rsp_valid, 1'b0);
        mem_drive = 32'hcafe_0042;
        mem_oe    = 1'b1;
        ACKD_n    = 1'b0;
        @(posedge clk); #1;
        ACKD_n = 1'b1;
        mem_oe = 1'b0;
        check("late_ack rsp_valid", rsp_valid, 1'b1);
        check("late_ack rsp_err", rsp_err, 1'b0);
        check("late_ack rsp_rdata", rsp_rdata, 32'hcafe_0042);
        @(posedge clk); #1;

        // Reset pulsed while a store is on the bus.
        issue(1'b1, 2'b00, 1'b0, 32'h0800_0030, 32'hcafe_f00d);
        check("midrst ddt_store", DDT, 32'hcafe_f00d);
        @(posedge clk); #1;
        check("midrst mreq_before", MREQ, 1'b1);
        #1;
        rst = 1'b1;
        #1;
        check("midrst mreq_drop", MREQ, 1'b0);
        check("midrst busy", busy, 1'b0);
        check_released("midrst");
        #3;
        rst = 1'b0;
        stray = 0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            if (rsp_valid || MREQ) stray++;
        end
        check("midrst no_rsp", stray, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
